// File: rtl/alu2_acc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : alu2_acc_sequencer
// Brief    : Command sequencer and accumulator wrapped around the alu2 datapath.
//            Optional status outputs (res_zero, res_carry) under ALU2_STATUS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu2_acc_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_c,
    input  logic [WIDTH-1:0] alu_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
`ifdef ALU2_STATUS_EN
    ,
    output logic             res_zero,
    output logic             res_carry
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_c;
    logic [CNT_W-1:0] r_remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = cmd_load ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_remaining == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The accumulator survives across commands; only reset or a load changes it outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_b         <= '0;
            r_c         <= 2'b00;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_b         <= cmd_data;
            r_c         <= cmd_op;
            r_remaining <= cmd_cnt;
            if (cmd_load) begin
                r_acc <= cmd_data;
            end
        end else if (r_state == S_EXEC) begin
            r_acc <= alu_f;
            if (r_remaining != '0) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign alu_a    = r_acc;
    assign alu_b    = r_b;
    assign alu_c    = r_c;
    assign res_data = r_acc;

`ifdef ALU2_STATUS_EN
    logic [WIDTH:0] w_sum;
    logic           r_carry;

    // Carry is recomputed locally because alu2 does not export its carry out.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_b} + (WIDTH+1)'(r_c[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_carry <= 1'b0;
        end else if ((r_state == S_EXEC) && !r_c[1] && w_sum[WIDTH]) begin
            r_carry <= 1'b1;
        end
    end

    assign res_zero  = (r_acc == '0);
    assign res_carry = r_carry;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu2_acc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_alu2_acc_sequencer
// Brief    : Directed self-checking bench for alu2_acc_sequencer with an alu2 model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu2_acc_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_c;
    logic [3:0] alu_f;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
`ifdef ALU2_STATUS_EN
    logic       res_zero;
    logic       res_carry;
`endif

    int checks   = 0;
    int failures = 0;

    alu2_acc_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_f     (alu_f),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef ALU2_STATUS_EN
        ,
        .res_zero  (res_zero),
        .res_carry (res_carry)
`endif
    );

    // Combinational alu2 model, carry out dropped.
    always_comb begin
        alu_f = 4'h0;
        case (alu_c)
            2'b00:   alu_f = alu_a + alu_b;
            2'b01:   alu_f = alu_a + alu_b + 4'h1;
            2'b10:   alu_f = alu_a & alu_b;
            default: alu_f = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the accepting edge with cmd_valid dropped.
    task automatic send(input logic ld, input logic [1:0] op, input logic [3:0] d,
                        input logic [3:0] cnt);
        int n;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = cnt;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Counts edges after the accept until res_valid, then checks latency and data.
    task automatic wait_result(input string tag, input logic [3:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, {28'd0, res_data}, {28'd0, exp});
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        int n_valid;
        int n_both;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;
        cmd_cnt   = 4'h0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_acc", res_data, 4'h0);
        check("rst_alu_b", alu_b, 4'h0);
        check("rst_alu_c", alu_c, 2'b00);
        rst = 1'b0;

        // Test 1: load then repeated add.
        send(1'b1, 2'b00, 4'h3, 4'h0);
        wait_result("t1_load", 4'h3, 0);
        release_result();
        send(1'b0, 2'b00, 4'h2, 4'h2);
        check("t1_alu_b", alu_b, 4'h2);
        wait_result("t1_add", 4'h9, 3);
        check("t1_cmd_ready", cmd_ready, 1'b0);
        release_result();

        // Test 2: wraparound to zero.
        send(1'b1, 2'b00, 4'hF, 4'h0);
        wait_result("t2_load", 4'hF, 0);
        release_result();
        send(1'b0, 2'b00, 4'h1, 4'h0);
        wait_result("t2_wrap", 4'h0, 1);
`ifdef ALU2_STATUS_EN
        check("t2_zero", res_zero, 1'b1);
        check("t2_carry", res_carry, 1'b1);
`endif
        release_result();

        // Test 3: remaining op codes.
        send(1'b1, 2'b00, 4'h5, 4'h0);
        wait_result("t3_load5", 4'h5, 0);
`ifdef ALU2_STATUS_EN
        check("t3_carry_clr", res_carry, 1'b0);
        check("t3_nonzero", res_zero, 1'b0);
`endif
        release_result();
        send(1'b0, 2'b01, 4'h4, 4'h0);
        wait_result("t3_addc", 4'hA, 1);
        release_result();
        send(1'b1, 2'b00, 4'hC, 4'h0);
        wait_result("t3_loadC", 4'hC, 0);
        release_result();
        send(1'b0, 2'b10, 4'hA, 4'h0);
        check("t3_alu_c", alu_c, 2'b10);
        wait_result("t3_and", 4'h8, 1);
        release_result();
        send(1'b1, 2'b00, 4'h6, 4'h0);
        wait_result("t3_load6", 4'h6, 0);
        release_result();
        send(1'b0, 2'b11, 4'h3, 4'h1);
        wait_result("t3_xor", 4'h6, 2);
        release_result();

        // Test 4: backpressure with a competing command held on the input.
        send(1'b1, 2'b00, 4'h7, 4'h0);
        wait_result("t4_load", 4'h7, 0);
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 4'h2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_hold_valid", res_valid, 1'b1);
            check("t4_hold_data", res_data, 4'h7);
            check("t4_hold_cmd_ready", cmd_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("t4_idle_valid", res_valid, 1'b0);
        check("t4_idle_ready", cmd_ready, 1'b1);
        check("t4_not_taken", res_data, 4'h7);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("t4_second_valid", res_valid, 1'b1);
        check("t4_second_data", res_data, 4'h2);
        release_result();

        // Test 5: reset in the middle of a long op.
        send(1'b0, 2'b00, 4'h1, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("t5_running", res_data, 4'h5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_res_valid", res_valid, 1'b0);
        check("t5_cmd_ready", cmd_ready, 1'b1);
        check("t5_acc", res_data, 4'h0);
        check("t5_alu_b", alu_b, 4'h0);

        // Test 6: back-to-back loads, consumer always ready.
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 4'hB;
        n_valid   = 0;
        n_both    = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) n_valid++;
            if (res_valid && cmd_ready) n_both++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        check("t6_results", n_valid, 4);
        check("t6_exclusive", n_both, 0);
        check("t6_data", res_data, 4'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
